// File: rtl/mac_div_pkg.sv
// Shared widths for the 4x4 MAC and its pipelined divider companion.
// Holds the operand width and the derived product, remainder and stage-record widths.
package mac_div_pkg;

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int rem_w(input int n);
    return n + 1;
  endfunction

  localparam int MAC_WIDTH  = 4;
  localparam int PROD_WIDTH = prod_w(MAC_WIDTH);
  localparam int REM_WIDTH  = rem_w(MAC_WIDTH);

  localparam int DVD_WIDTH  = PROD_WIDTH;
  localparam int QUO_WIDTH  = PROD_WIDTH;
  localparam int DSR_WIDTH  = MAC_WIDTH;

endpackage

// File: rtl/div_stage.sv
// One combinational restoring-division step: shift in a dividend bit, compare, subtract.
// Ports: rem_in/bit_in/divisor in; rem_out (next partial remainder) and q_bit out.
module div_stage
  import mac_div_pkg::*;
#(
  parameter int W  = MAC_WIDTH,
  parameter int RW = REM_WIDTH
) (
  input  logic [RW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [W-1:0]  divisor,
  output logic [RW-1:0] rem_out,
  output logic          q_bit
);

  logic [RW-1:0] p;
  logic          unused_msb;

  // A settled remainder is always below the divisor, so its top bit is zero.
  assign unused_msb = rem_in[RW-1];

  assign p       = {rem_in[W-1:0], bit_in};
  assign q_bit   = (p >= {1'b0, divisor});
  assign rem_out = q_bit ? (p - {1'b0, divisor}) : p;

endmodule

// File: rtl/pipelined_divider.sv
// Pipelined restoring divider, one quotient bit per registered stage, 2N stages.
// Ports: clk, rst_n, in_valid/in_ready/dividend/divisor, out_valid/out_ready/quotient/remainder/div_by_zero.
module pipelined_divider
  import mac_div_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero
);

  localparam int DW = prod_w(WIDTH);
  localparam int RW = rem_w(WIDTH);
  localparam int NS = DW;

  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   rem;
    logic [DW-1:0]   dvd;
    logic [DW-1:0]   quo;
    logic [WIDTH-1:0] dsr;
    logic            zero;
  } rec_t;

  rec_t stg_q [NS];
  rec_t stg_d [NS];
  rec_t src   [NS];

  logic adv;
  logic unused_tail;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [RW-1:0] rem_n;
    logic          qb;
    logic          fix;

    if (k == 0) begin : g_head
      assign src[k] = '{
        valid: in_valid,
        rem:   '0,
        dvd:   dividend,
        quo:   '0,
        dsr:   divisor,
        zero:  (divisor == '0)
      };
    end else begin : g_body
      assign src[k] = stg_q[k-1];
    end

    div_stage #(
      .W  (WIDTH),
      .RW (RW)
    ) u_step (
      .rem_in  (src[k].rem),
      .bit_in  (src[k].dvd[DW-1]),
      .divisor (src[k].dsr),
      .rem_out (rem_n),
      .q_bit   (qb)
    );

    // Zero divisor: arithmetic path is replaced only on the last step.
    assign fix = (k == NS - 1) && src[k].zero;

    assign stg_d[k] = '{
      valid: src[k].valid,
      rem:   fix ? '0 : rem_n,
      dvd:   {src[k].dvd[DW-2:0], 1'b0},
      quo:   fix ? '1 : {src[k].quo[DW-2:0], qb},
      dsr:   src[k].dsr,
      zero:  src[k].zero
    };
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NS; k++) stg_q[k] <= '0;
    end else if (adv) begin
      for (int k = 0; k < NS; k++) stg_q[k] <= stg_d[k];
    end
  end

  assign out_valid   = stg_q[NS-1].valid;
  assign quotient    = stg_q[NS-1].quo;
  assign remainder   = stg_q[NS-1].rem[WIDTH-1:0];
  assign div_by_zero = stg_q[NS-1].zero;

  assign unused_tail = ^{stg_q[NS-1].dvd,
                         stg_q[NS-1].dsr,
                         stg_q[NS-1].rem[RW-1]};

endmodule

// File: tb/tb_pipelined_divider.sv
// Directed and scoreboard bench for pipelined_divider.
// Drives after the rising edge, samples on the falling edge.
module tb_pipelined_divider;
  import mac_div_pkg::*;

  typedef struct {
    logic [PROD_WIDTH-1:0] a;
    logic [MAC_WIDTH-1:0]  b;
    logic [PROD_WIDTH-1:0] q;
    logic [MAC_WIDTH-1:0]  r;
    logic                  z;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] dividend;
  logic [MAC_WIDTH-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [PROD_WIDTH-1:0] quotient;
  logic [MAC_WIDTH-1:0]  remainder;
  logic                  div_by_zero;

  int checks    = 0;
  int failures  = 0;
  int delivered = 0;
  int n;
  int wk;
  logic rnd_on = 1'b0;
  exp_t sbq[$];
  exp_t me;
  logic [PROD_WIDTH-1:0] hq;
  logic [MAC_WIDTH-1:0]  hr;
  logic                  hz;
  logic [11:0]           v;

  pipelined_divider #(.WIDTH(MAC_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [PROD_WIDTH-1:0] a,
                              input logic [MAC_WIDTH-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1;
      e.r = '0;
      e.z = 1'b1;
    end else begin
      e.q = a / PROD_WIDTH'(b);
      e.r = MAC_WIDTH'(a % PROD_WIDTH'(b));
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic send(input exp_t e);
    int t = 0;
    dividend = e.a;
    divisor  = e.b;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) chk("send_timeout", 0, 1);
    else sbq.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!out_valid && cnt < 40);
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("extra_result", 1, 0);
      end else begin
        me = sbq.pop_front();
        delivered++;
        chk("quotient", quotient, me.q);
        chk("remainder", remainder, me.r);
        chk("div_by_zero", div_by_zero, me.z);
        if (me.b != 0) begin
          chk("identity", 32'(quotient) * 32'(me.b) + 32'(remainder),
              32'(me.a));
          chk("rem_lt_div", 32'(remainder < me.b), 1);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    send('{a: 8'h36, b: 4'h9, q: 8'h06, r: 4'h0, z: 1'b0});
    wait_out(n);
    chk("latency", n, 8);
    @(posedge clk);
    #1;

    send('{a: 8'h64, b: 4'h7, q: 8'h0E, r: 4'h2, z: 1'b0});
    send('{a: 8'hFF, b: 4'hF, q: 8'h11, r: 4'h0, z: 1'b0});
    send('{a: 8'hFF, b: 4'h1, q: 8'hFF, r: 4'h0, z: 1'b0});
    send('{a: 8'h0F, b: 4'hF, q: 8'h01, r: 4'h0, z: 1'b0});
    wait_out(n);
    chk("b2b_first", n, 5);
    repeat (3) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, 1);
    end
    drain();

    send('{a: 8'h2A, b: 4'h0, q: 8'hFF, r: 4'h0, z: 1'b1});
    send('{a: 8'h2A, b: 4'h5, q: 8'h08, r: 4'h2, z: 1'b0});
    drain();

    delivered = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(mk(8'(37 * i + 11), 4'(i % 15 + 1)));
      end
      begin
        wk = 0;
        while (delivered < 3 && wk < 100) begin
          @(negedge clk);
          wk++;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hq = quotient;
        hr = remainder;
        hz = div_by_zero;
        chk("stall_valid", out_valid, 1);
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("hold_quotient", quotient, hq);
          chk("hold_remainder", remainder, hr);
          chk("hold_dbz", div_by_zero, hz);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", delivered, 10);

    for (int i = 0; i < 5; i++)
      send(mk(8'(53 * i + 7), 4'(i + 2)));
    wait_out(n);
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_quotient", quotient, 0);
    sbq.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send('{a: 8'h36, b: 4'h9, q: 8'h06, r: 4'h0, z: 1'b0});
    wait_out(n);
    chk("post_rst_latency", n, 8);
    drain();

    delivered = 0;
    rnd_on = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      v = 12'(i);
      send(mk(v[11:4], v[3:0]));
    end
    rnd_on = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();
    chk("sweep_count", delivered, 4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
